// File: rtl/compress_pkg.sv
// Shared definitions for the block-compression scheduler: FSM encoding and default grid size.
package compress_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    WAIT   = 3'd2,
    STORE  = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } state_t;

  localparam int NUM_STATES        = 6;
  localparam int STATE_W           = $clog2(NUM_STATES);
  localparam int DEF_BLOCKS_IN_ROW = 80;
  localparam int DEF_BLOCKS_IN_COL = 60;

endpackage

// File: rtl/compress_sched_if.sv
// Control and core-handshake bundle between the scheduler and its environment.
interface compress_sched_if #(
  parameter int ROW_W = 6,
  parameter int COL_W = 7
);
  logic             start_img;
  logic             abort;
  logic             core_done;
  logic             core_start;
  logic [ROW_W-1:0] blk_row;
  logic [COL_W-1:0] blk_col;
  logic             store_en;
  logic             img_done;
  logic             busy;
  logic             err;

  modport master (
    input  start_img, abort, core_done,
    output core_start, blk_row, blk_col, store_en, img_done, busy, err
  );

  modport slave (
    output start_img, abort, core_done,
    input  core_start, blk_row, blk_col, store_en, img_done, busy, err
  );
endinterface

// File: rtl/blk_raster_ctr.sv
// Raster-order block index generator: column-fastest walk over a NUM_ROWS x NUM_COLS grid.
module blk_raster_ctr #(
  parameter int NUM_COLS = 80,
  parameter int NUM_ROWS = 60,
  parameter int COL_W    = 7,
  parameter int ROW_W    = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             restart,
  input  logic             advance,
  output logic [ROW_W-1:0] blk_row,
  output logic [COL_W-1:0] blk_col,
  output logic             last
);

  logic [ROW_W-1:0] row_reg;
  logic [COL_W-1:0] col_reg;
  logic             col_last;

  assign col_last = (col_reg == COL_W'(NUM_COLS - 1));
  assign last     = col_last && (row_reg == ROW_W'(NUM_ROWS - 1));
  assign blk_row  = row_reg;
  assign blk_col  = col_reg;

  // restart wins so a new image always begins at (0,0)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_reg <= '0;
      col_reg <= '0;
    end else if (restart) begin
      row_reg <= '0;
      col_reg <= '0;
    end else if (advance) begin
      if (col_last) begin
        col_reg <= '0;
        row_reg <= row_reg + 1'b1;
      end else begin
        col_reg <= col_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ff_en.sv
// Generic enabled register with asynchronous active-low reset to a parameterised value.
module ff_en #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/compress_sched.sv
// Sequences one shared compress_block core over every block of an image, with watchdog and abort.
module compress_sched
  import compress_pkg::*;
#(
  parameter int NUM_BLOCKS_IN_ROW = DEF_BLOCKS_IN_ROW,
  parameter int NUM_BLOCKS_IN_COL = DEF_BLOCKS_IN_COL,
  parameter int COL_W             = 7,
  parameter int ROW_W             = 6,
  parameter int TIMEOUT           = 1023,
  parameter int TMO_W             = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  compress_sched_if.master    bus
);

  logic [STATE_W-1:0] state_reg;
  state_t             state;
  state_t             state_next;
  logic [TMO_W-1:0]   wdog_reg;
  logic               err_reg;
  logic               restart;
  logic               advance;
  logic               last_blk;
  logic               wdog_expired;

  assign state        = state_t'(state_reg);
  assign wdog_expired = (wdog_reg == TMO_W'(TIMEOUT));

  ff_en #(
    .W       (STATE_W),
    .RST_VAL (IDLE)
  ) u_state_ff (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (1'b1),
    .d     (state_next),
    .q     (state_reg)
  );

  blk_raster_ctr #(
    .NUM_COLS (NUM_BLOCKS_IN_ROW),
    .NUM_ROWS (NUM_BLOCKS_IN_COL),
    .COL_W    (COL_W),
    .ROW_W    (ROW_W)
  ) u_raster (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart),
    .advance (advance),
    .blk_row (bus.blk_row),
    .blk_col (bus.blk_col),
    .last    (last_blk)
  );

  always_comb begin
    state_next = state;
    restart    = 1'b0;
    advance    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start_img) begin
          restart    = 1'b1;
          state_next = LAUNCH;
        end
      end
      LAUNCH: state_next = WAIT;
      WAIT: begin
        if (bus.core_done) begin
          state_next = STORE;
        end else if (wdog_expired) begin
          state_next = ERR;
        end
      end
      STORE: begin
        if (last_blk) begin
          state_next = DONE;
        end else begin
          advance    = 1'b1;
          state_next = LAUNCH;
        end
      end
      DONE:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // abort overrides everything, including a core_done or timeout in the same cycle
    if (bus.abort && (state != IDLE)) begin
      state_next = IDLE;
      advance    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_reg <= '0;
      err_reg  <= 1'b0;
    end else begin
      if (state == LAUNCH) begin
        wdog_reg <= '0;
      end else if ((state == WAIT) && !bus.core_done && !wdog_expired) begin
        wdog_reg <= wdog_reg + 1'b1;
      end
      // err is sticky until the next image is actually accepted
      if ((state == IDLE) && bus.start_img) begin
        err_reg <= 1'b0;
      end else if (state == ERR) begin
        err_reg <= 1'b1;
      end
    end
  end

  assign bus.core_start = (state == LAUNCH);
  assign bus.store_en   = (state == STORE);
  assign bus.img_done   = (state == DONE);
  assign bus.busy       = (state != IDLE);
  assign bus.err        = err_reg;

endmodule

// File: tb/tb_compress_sched.sv
// Directed bench: 2x2 grid (TIMEOUT=8, core latency 5) and full 60x80 grid (core latency 3).
module tb_compress_sched;

  logic clk;
  logic rst_n;

  compress_sched_if #(.ROW_W(1), .COL_W(1)) sb ();
  compress_sched_if #(.ROW_W(6), .COL_W(7)) fb ();

  compress_sched #(
    .NUM_BLOCKS_IN_ROW (2),
    .NUM_BLOCKS_IN_COL (2),
    .COL_W             (1),
    .ROW_W             (1),
    .TIMEOUT           (8),
    .TMO_W             (4)
  ) dut_small (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sb)
  );

  compress_sched dut_full (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (fb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  // core models: done pulses LAT cycles after the core_start cycle
  logic s_model_done, s_man_done, s_en;
  logic f_model_done, f_en;
  assign sb.core_done = s_model_done | s_man_done;
  assign fb.core_done = f_model_done;

  initial begin
    int cnt;
    logic pend;
    s_model_done = 1'b0;
    pend = 1'b0;
    cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      s_model_done = 1'b0;
      if (!s_en) pend = 1'b0;
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          s_model_done = 1'b1;
          pend = 1'b0;
        end
      end
      if (sb.core_start && s_en) begin
        pend = 1'b1;
        cnt = 5;
      end
    end
  end

  initial begin
    int cnt;
    logic pend;
    f_model_done = 1'b0;
    pend = 1'b0;
    cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      f_model_done = 1'b0;
      if (!f_en) pend = 1'b0;
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          f_model_done = 1'b1;
          pend = 1'b0;
        end
      end
      if (fb.core_start && f_en) begin
        pend = 1'b1;
        cnt = 3;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("vec %0d %s obs=%0h exp=%0h", vectors, tag, obs, exp);
  endtask

  function automatic logic [3:0] small_flags();
    return {sb.core_start, sb.store_en, sb.img_done, sb.busy};
  endfunction

  // One 2x2 image from cycle 0 (start already driven by caller context); optional stray start pulse.
  task automatic run_small(input int pulse_cyc, input string name);
    int stores;
    logic exp_cs, exp_st, exp_dn, exp_bz;
    logic [1:0] k;
    stores = 0;
    sb.start_img = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      tick();
      sb.start_img = (c == pulse_cyc);
      exp_cs = (c % 7 == 1) && (c <= 22);
      exp_st = (c % 7 == 0) && (c >= 7) && (c <= 28);
      exp_dn = (c == 29);
      exp_bz = (c <= 29);
      chk($sformatf("%s_c%0d_flags", name, c), {28'd0, small_flags()},
          {28'd0, exp_cs, exp_st, exp_dn, exp_bz});
      if (exp_st) begin
        k = 2'((c / 7) - 1);
        chk($sformatf("%s_c%0d_idx", name, c), {30'd0, sb.blk_row, sb.blk_col}, {30'd0, k});
      end
      if (sb.store_en === 1'b1) stores++;
    end
    sb.start_img = 1'b0;
    chk($sformatf("%s_store_count", name), 32'(stores), 32'd4);
    chk($sformatf("%s_err", name), {31'd0, sb.err}, 32'd0);
  endtask

  initial begin
    int stores, dones, budget;
    logic [5:0] exp_r;
    logic [6:0] exp_c;
    logic seen_done;

    rst_n = 1'b0;
    sb.start_img = 1'b0; sb.abort = 1'b0; s_man_done = 1'b0; s_en = 1'b0;
    fb.start_img = 1'b0; fb.abort = 1'b0; f_en = 1'b0;
    repeat (3) tick();
    chk("reset_small_outs", {27'd0, small_flags(), sb.err}, 32'd0);
    chk("reset_small_idx", {30'd0, sb.blk_row, sb.blk_col}, 32'd0);
    chk("reset_full_outs", {27'd0, fb.core_start, fb.store_en, fb.img_done, fb.busy, fb.err}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_after_reset", {27'd0, small_flags(), sb.err}, 32'd0);

    // nominal 2x2 image
    s_en = 1'b1;
    run_small(-1, "img2x2");
    tick();

    // watchdog: core never answers
    s_en = 1'b0;
    sb.start_img = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      tick();
      sb.start_img = 1'b0;
      chk($sformatf("tmo_c%0d", c), {27'd0, small_flags(), sb.err},
          {27'd0, (c == 1), 1'b0, 1'b0, (c <= 11), (c >= 12)});
    end
    repeat (3) tick();
    chk("tmo_err_sticky", {31'd0, sb.err}, 32'd1);

    // restart clears err; abort together with core_done in WAIT
    sb.start_img = 1'b1;
    tick();
    sb.start_img = 1'b0;
    chk("restart_c1", {27'd0, small_flags(), sb.err}, {27'd0, 5'b10010});
    tick();
    chk("abort_c2_wait", {27'd0, small_flags()}, {27'd0, 4'b0001});
    sb.abort = 1'b1;
    s_man_done = 1'b1;
    tick();
    sb.abort = 1'b0;
    s_man_done = 1'b0;
    chk("abort_c3", {27'd0, small_flags(), sb.err}, 32'd0);
    tick();
    chk("abort_c4", {27'd0, small_flags(), sb.err}, 32'd0);

    // stray start during WAIT of block (0,1)
    s_en = 1'b1;
    run_small(10, "stray");
    tick();

    // reset during STORE of block (1,0)
    sb.start_img = 1'b1;
    for (int c = 1; c <= 21; c++) begin
      tick();
      sb.start_img = 1'b0;
    end
    chk("rst_store_pre", {29'd0, sb.store_en, sb.blk_row, sb.blk_col}, {29'd0, 3'b110});
    rst_n = 1'b0;
    #1;
    chk("rst_async_outs", {27'd0, small_flags(), sb.err}, 32'd0);
    chk("rst_async_idx", {30'd0, sb.blk_row, sb.blk_col}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_idle_wait", {28'd0, small_flags()}, 32'd0);
    sb.start_img = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      sb.start_img = 1'b0;
    end
    chk("rst_first_store", {29'd0, sb.store_en, sb.blk_row, sb.blk_col}, {29'd0, 3'b100});
    repeat (25) tick();

    // full 60x80 image, latency 3
    f_en = 1'b1;
    exp_r = '0; exp_c = '0;
    stores = 0; dones = 0; seen_done = 1'b0;
    budget = 26000;
    fb.start_img = 1'b1;
    while (budget > 0) begin
      tick();
      fb.start_img = 1'b0;
      budget--;
      if (fb.store_en === 1'b1) begin
        if (stores < 4800)
          chk($sformatf("full_idx_%0d", stores), {19'd0, fb.blk_row, fb.blk_col}, {19'd0, exp_r, exp_c});
        stores++;
        if (exp_c == 7'd79) begin
          exp_c = '0;
          exp_r = exp_r + 1'b1;
        end else begin
          exp_c = exp_c + 1'b1;
        end
      end
      if (fb.img_done === 1'b1) begin
        dones++;
        seen_done = 1'b1;
      end else if (seen_done && fb.busy === 1'b0) begin
        break;
      end
    end
    chk("full_finished_in_budget", {31'd0, (budget > 0)}, 32'd1);
    chk("full_store_count", 32'(stores), 32'd4800);
    chk("full_done_count", 32'(dones), 32'd1);
    chk("full_err", {31'd0, fb.err}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/compress_sched.md
COMPRESS_SCHED -- requirements
Module: compress_sched

Interface
REQ-001 Parameter NUM_BLOCKS_IN_ROW, default 80: block columns per image (IMG_COLS/BLOCK_SIZE).
REQ-002 Parameter NUM_BLOCKS_IN_COL, default 60: block rows per image (IMG_ROWS/BLOCK_SIZE).
REQ-003 Parameter COL_W, default 7: width of the block column index.
REQ-004 Parameter ROW_W, default 6: width of the block row index.
REQ-005 Parameter TIMEOUT, default 1023: maximum number of WAIT cycles allowed per block.
REQ-006 Parameter TMO_W, default 10: width of the watchdog counter.
REQ-007 clk  in  1  the single clock; all logic is rising-edge.
REQ-008 rst_n  in  1  reset, asynchronous and active-low.
REQ-009 start_img  in  1  request to start an image; sampled only in IDLE.
REQ-010 abort  in  1  synchronous abort of the current image.
REQ-011 core_done  in  1  one-cycle completion pulse from the shared compress_block core.
REQ-012 core_start  out  1  one-cycle start pulse to the core.
REQ-013 blk_row  out  ROW_W  block row currently loaded into the core.
REQ-014 blk_col  out  COL_W  block column currently loaded into the core.
REQ-015 store_en  out  1  one-cycle pulse that writes the core coefficients at (blk_row, blk_col).
REQ-016 img_done  out  1  one-cycle pulse when the whole image is complete.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 err  out  1  sticky watchdog error flag.

Function
REQ-019 The FSM SHALL have six states: IDLE, LAUNCH, WAIT, STORE, DONE, ERR.
REQ-020 IDLE: when start_img=1, the FSM SHALL clear blk_row/blk_col to 0, clear err, and move to LAUNCH on the next edge.
REQ-021 LAUNCH SHALL last exactly 1 cycle with core_start=1, clear the watchdog to 0, and then move to WAIT.
REQ-022 WAIT: when core_done=1, the FSM SHALL move to STORE; otherwise the watchdog SHALL increment each cycle.
REQ-023 WAIT: if the watchdog equals TIMEOUT and core_done=0, the FSM SHALL move to ERR, so WAIT lasts at most TIMEOUT+1 cycles.
REQ-024 STORE SHALL last 1 cycle with store_en=1.
REQ-025 STORE: if (blk_row, blk_col) is the last block (NUM_BLOCKS_IN_COL-1, NUM_BLOCKS_IN_ROW-1), the FSM SHALL move to DONE.
REQ-026 STORE, any other block: blk_col SHALL increment, or wrap to 0 with blk_row incrementing, and the FSM SHALL move to LAUNCH.
REQ-027 DONE SHALL last 1 cycle with img_done=1, then return to IDLE.
REQ-028 ERR SHALL last 1 cycle, set err=1, then return to IDLE.
REQ-029 err SHALL remain 1 until the next accepted start_img.
REQ-030 blk_row/blk_col SHALL be held stable from LAUNCH through STORE of each block.
REQ-031 abort=1 in any non-IDLE state SHALL force IDLE on the next edge with no store_en or img_done; abort SHALL take priority over core_done and timeout.
REQ-032 core_done outside WAIT SHALL be ignored.
REQ-033 start_img outside IDLE SHALL be ignored.
REQ-034 Latency: start_img accepted in cycle 0 gives core_start in cycle 1.
REQ-035 Per-block period: a core with done latency L (done seen L cycles after the core_start cycle) gives a per-block period of L+2 cycles.
REQ-036 store_en, img_done and core_start SHALL be Moore outputs decoded from the registered state.

Reset
REQ-037 rst_n=0 SHALL asynchronously force state=IDLE and blk_row=blk_col=0.
REQ-038 rst_n=0 SHALL asynchronously force watchdog=0, err=0, and core_start=store_en=img_done=busy=0.
REQ-039 Reset asserted mid-image SHALL discard all progress; after release, the block SHALL wait in IDLE for start_img.

Structure
REQ-040 The state encoding, state-count localparams and default grid dimensions SHALL reside in the shared package compress_pkg.
REQ-041 The state register SHALL use the existing ff_en flop with rst_val = IDLE encoding.
REQ-042 Raster index generation SHALL be the sub-module blk_raster_ctr, with ports restart, advance, blk_row, blk_col and last.

Verification
REQ-043 Grid 2x2, core latency 5, start_img pulse: core_start at cycles 1, 8, 15, 22; store_en with (0,0),(0,1),(1,0),(1,1) at cycles 7, 14, 21, 28; img_done at cycle 29; busy low at cycle 30.
REQ-044 TIMEOUT=8, core never responds: LAUNCH at cycle 1, WAIT for cycles 2-10, ERR at cycle 11, err=1 from cycle 12 until the next start_img; no store_en.
REQ-045 abort and core_done asserted in the same WAIT cycle: next state is IDLE, no store_en, err=0, indices reset on the next start.
REQ-046 start_img pulsed during WAIT of block (0,1): ignored; sequence and indices are unchanged; exactly 4 store_en pulses occur.
REQ-047 rst_n asserted during STORE of block (1,0): all outputs are 0 immediately (asynchronously); after release plus start_img, the first store_en is at (0,0).
REQ-048 Grid 60x80 full image, latency 3: exactly 4800 store_en pulses in raster order, the column wraps at 79, and a single img_done occurs.
